// File: rtl/switch_allocator_if.sv
// Switch allocator port bundle: per-VC request information in, per-port
// buffer-read selects and crossbar selects out.
//
// Handshake: there is no ready/backpressure path. A VC offers a flit by
// holding request_i high; it was granted in a cycle exactly when its input
// row of vc_sel_o is non-zero (valid_sel_o high) in that same cycle. The
// granted VC is read and the crossbar moves the flit in that cycle.
// Until a grant comes, the requester keeps request_i high with stable
// routing fields.
interface switch_allocator_if #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
);
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]                 request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]  out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                 on_off_i;

  logic [PORT_NUM-1:0][VC_NUM-1:0]                 vc_sel_o;
  logic [PORT_NUM-1:0]                             valid_sel_o;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]              xb_sel_o;
  logic [PORT_NUM-1:0]                             valid_flit_o;

  // Input block / router side.
  modport master (
    output request_i, out_port_i, downstream_vc_i, on_off_i,
    input  vc_sel_o, valid_sel_o, xb_sel_o, valid_flit_o
  );

  // Allocator side.
  modport slave (
    input  request_i, out_port_i, downstream_vc_i, on_off_i,
    output vc_sel_o, valid_sel_o, xb_sel_o, valid_flit_o
  );
endinterface

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator.
// Stage 1 picks one eligible VC per input port by round-robin.
// Stage 2 picks one stage-1 winner per output port by round-robin.
// Grants are combinational. Only the round-robin pointers are registered.
// A pointer moves past the granted index only when a real grant happens.
module switch_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave sa
);
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  // on/off table padded to full index range so any encoded value is safe to look up
  localparam int PORT_PAD  = 1 << PORT_SIZE;
  localparam int VC_PAD    = 1 << VC_SIZE;

  logic [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr;

  logic [PORT_PAD-1:0][VC_PAD-1:0]    on_off_pad;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    elig;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   w1;
  logic [PORT_NUM-1:0]                has1;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] tgt;
  logic [PORT_NUM-1:0]                in_gnt;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_win;
  logic [PORT_NUM-1:0]                out_gnt;

  // Copy on/off credits into a zero-padded table. Unused encodings read as "off".
  always_comb begin
    on_off_pad = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        on_off_pad[p][v] = sa.on_off_i[p][v];
      end
    end
  end

  // A VC competes only if it requests and its downstream VC is switched on.
  always_comb begin
    elig = '0;
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      for (int vc = 0; vc < VC_NUM; vc++) begin
        elig[ip][vc] = sa.request_i[ip][vc]
                     & on_off_pad[sa.out_port_i[ip][vc]][sa.downstream_vc_i[ip][vc]];
      end
    end
  end

  // Stage 1: per input port, the first eligible VC at or after in_ptr wins.
  always_comb begin
    int idx;
    w1   = '0;
    has1 = '0;
    tgt  = '0;
    idx  = 0;
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        idx = int'(in_ptr[ip]) + k;
        if (idx >= VC_NUM) begin
          idx = idx - VC_NUM;
        end
        if (!has1[ip] && elig[ip][idx]) begin
          has1[ip] = 1'b1;
          w1[ip]   = VC_SIZE'(idx);
        end
      end
      tgt[ip] = sa.out_port_i[ip][w1[ip]];
    end
  end

  // Stage 2: per output port, the first stage-1 winner at or after out_ptr that targets it wins.
  always_comb begin
    int idx;
    out_gnt = '0;
    xb_win  = '0;
    in_gnt  = '0;
    idx     = 0;
    for (int op = 0; op < PORT_NUM; op++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        idx = int'(out_ptr[op]) + k;
        if (idx >= PORT_NUM) begin
          idx = idx - PORT_NUM;
        end
        if (!out_gnt[op] && has1[idx] && (tgt[idx] == PORT_SIZE'(op))) begin
          out_gnt[op] = 1'b1;
          xb_win[op]  = PORT_SIZE'(idx);
          in_gnt[idx] = 1'b1;
        end
      end
    end
  end

  // Drive grants. Everything is held at zero while reset is asserted.
  always_comb begin
    sa.vc_sel_o     = '0;
    sa.valid_sel_o  = '0;
    sa.xb_sel_o     = '0;
    sa.valid_flit_o = '0;
    if (!rst) begin
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        if (in_gnt[ip]) begin
          sa.vc_sel_o[ip][w1[ip]] = 1'b1;
        end
      end
      sa.valid_sel_o  = in_gnt;
      sa.xb_sel_o     = xb_win;
      sa.valid_flit_o = out_gnt;
    end
  end

  // Advance each pointer just past its granted index, wrapping at the last index.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ptr  <= '0;
      out_ptr <= '0;
    end else begin
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        if (in_gnt[ip]) begin
          in_ptr[ip] <= (w1[ip] == VC_SIZE'(VC_NUM - 1)) ? '0 : w1[ip] + 1'b1;
        end
      end
      for (int op = 0; op < PORT_NUM; op++) begin
        if (out_gnt[op]) begin
          out_ptr[op] <= (xb_win[op] == PORT_SIZE'(PORT_NUM - 1)) ? '0 : xb_win[op] + 1'b1;
        end
      end
    end
  end
endmodule
